// File: rtl/vga_pkg.sv
// vga_pkg
// Shared 640x480@60Hz timing constants for the raster generator and the
// text display that consumes its coordinates.
// Contents:
//   VGA_H_* / VGA_V_*  : active, porch and sync lengths plus line/frame totals
//   VGA_COORD_W        : width of pixel_x / pixel_y (10 bits covers 0..799)
//   VGA_DIV_W          : width of the pixel-tick divider count (PIX_DIV <= 16)
//   VGA_SYNC_POL       : asserted sync level (0 = active-low)
//   in_window()        : half-open range test used by the sync decode
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_COORD_W  = 10;
  localparam int VGA_DIV_W    = 4;
  localparam bit VGA_SYNC_POL = 1'b0;

  // True when lo <= v < hi.
  function automatic logic in_window(input logic [VGA_COORD_W-1:0] v,
                                     input logic [VGA_COORD_W-1:0] lo,
                                     input logic [VGA_COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_pix_tick_div.sv
// vga_pix_tick_div
// Divides the system clock down to the pixel rate. pix_tick is a one-clk
// pulse once every PIX_DIV clocks; with PIX_DIV = 1 it stays high.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   pix_tick : one-clk pixel-period strobe (low during reset)
module vga_pix_tick_div
  import vga_pkg::*;
#(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam logic [VGA_DIV_W-1:0] DIV_LAST = VGA_DIV_W'(PIX_DIV - 1);

  logic [VGA_DIV_W-1:0] div_cnt_q;
  logic [VGA_DIV_W-1:0] div_cnt_d;
  logic                 pix_tick_q;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
  end

  // The strobe is registered off the terminal count so it is glitch-free
  // and held low in reset even when PIX_DIV = 1; the first strobe lands
  // PIX_DIV clocks after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      pix_tick_q <= (div_cnt_q == DIV_LAST);
    end
  end

  assign pix_tick = pix_tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480@60Hz raster timing: pixel coordinates, video_on, line/frame
// strobes and hsync/vsync. Sync is delayed SYNC_DELAY pixel ticks behind
// the coordinates so it lines up with the display's registered RGB.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   pix_tick    : one-clk pulse per pixel period
//   pixel_x/y   : current horizontal / vertical count
//   video_on    : inside the visible area
//   hsync/vsync : sync outputs, asserted level SYNC_POL
//   line_start  : high for the pixel period where pixel_x == 0
//   frame_start : high for the pixel period where pixel_x == 0 and pixel_y == 0
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit SYNC_POL   = VGA_SYNC_POL,
  parameter int PIX_DIV    = 4,
  parameter int SYNC_DELAY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   pix_tick,
  output logic [VGA_COORD_W-1:0] pixel_x,
  output logic [VGA_COORD_W-1:0] pixel_y,
  output logic                   video_on,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   line_start,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [VGA_COORD_W-1:0] H_LAST   = VGA_COORD_W'(H_TOTAL - 1);
  localparam logic [VGA_COORD_W-1:0] V_LAST   = VGA_COORD_W'(V_TOTAL - 1);
  localparam logic [VGA_COORD_W-1:0] H_VIS    = VGA_COORD_W'(H_ACTIVE);
  localparam logic [VGA_COORD_W-1:0] V_VIS    = VGA_COORD_W'(V_ACTIVE);
  localparam logic [VGA_COORD_W-1:0] HS_START = VGA_COORD_W'(H_ACTIVE + H_FP);
  localparam logic [VGA_COORD_W-1:0] HS_END   = VGA_COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VGA_COORD_W-1:0] VS_START = VGA_COORD_W'(V_ACTIVE + V_FP);
  localparam logic [VGA_COORD_W-1:0] VS_END   = VGA_COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_pix_div
    $error("vga_timing_gen: PIX_DIV must be in 1..16");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_bad_sync_delay
    $error("vga_timing_gen: SYNC_DELAY must be in 0..3");
  end
  if (H_TOTAL > (1 << VGA_COORD_W) || V_TOTAL > (1 << VGA_COORD_W)) begin : g_bad_totals
    $error("vga_timing_gen: line or frame total exceeds coordinate width");
  end

  logic                   pix_tick_w;
  logic [VGA_COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [VGA_COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic [VGA_COORD_W-1:0] pixel_x_q, pixel_y_q;
  logic                   video_on_q, video_on_d;
  logic                   line_start_q, line_start_d;
  logic                   frame_start_q, frame_start_d;
  logic                   hs_level, vs_level;
  logic [SYNC_DELAY:0]    hs_pipe_q, vs_pipe_q;

  vga_pix_tick_div #(
    .PIX_DIV(PIX_DIV)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .pix_tick(pix_tick_w)
  );

  // Decode of the current count and the next count. The frame wrap happens
  // on the same tick as the last line wrap, so there is never a dead pixel.
  always_comb begin
    h_cnt_d       = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
    v_cnt_d       = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
    video_on_d    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    line_start_d  = (h_cnt_q == '0);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    hs_level      = in_window(h_cnt_q, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_level      = in_window(v_cnt_q, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
  end

  // On each pixel tick the output registers take the decode of the count
  // and the count advances. Sync stage 0 is aligned with pixel_x; each
  // further stage adds one pixel of lag, and the last stage drives the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_pipe_q     <= {(SYNC_DELAY + 1){~SYNC_POL}};
      vs_pipe_q     <= {(SYNC_DELAY + 1){~SYNC_POL}};
    end else if (pix_tick_w) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pixel_x_q     <= h_cnt_q;
      pixel_y_q     <= v_cnt_q;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_pipe_q[0]  <= hs_level;
      vs_pipe_q[0]  <= vs_level;
      for (int k = 1; k <= SYNC_DELAY; k++) begin
        hs_pipe_q[k] <= hs_pipe_q[k-1];
        vs_pipe_q[k] <= vs_pipe_q[k-1];
      end
    end
  end

  assign pix_tick    = pix_tick_w;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hsync       = hs_pipe_q[SYNC_DELAY];
  assign vsync       = vs_pipe_q[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Three instances share clk/rst:
//   A: default 640x480 timing, PIX_DIV=4, SYNC_DELAY=1
//   B: default horizontal, short frame (13 lines), PIX_DIV=1, SYNC_DELAY=0
//   C: tiny raster, PIX_DIV=3, SYNC_DELAY=3, active-high sync
// Each clk the expected outputs of all three are derived from the number of
// clocks since reset release and queued; the queue is drained on negedge.
module tb_vga_timing_gen;

  localparam int PD  [3] = '{4, 1, 3};
  localparam int DL  [3] = '{1, 0, 3};
  localparam int HA  [3] = '{640, 640, 8};
  localparam int HFP [3] = '{16, 16, 2};
  localparam int HSW [3] = '{96, 96, 3};
  localparam int HBP [3] = '{48, 48, 2};
  localparam int VA  [3] = '{480, 6, 4};
  localparam int VFP [3] = '{10, 2, 1};
  localparam int VSW [3] = '{2, 2, 2};
  localparam int VBP [3] = '{33, 3, 1};
  localparam int POL [3] = '{0, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic       aTick, aVid, aHs, aVs, aLs, aFs;
  logic [9:0] aX, aY;
  logic       bTick, bVid, bHs, bVs, bLs, bFs;
  logic [9:0] bX, bY;
  logic       cTick, cVid, cHs, cVs, cLs, cFs;
  logic [9:0] cX, cY;
  logic [25:0] obsA, obsB, obsC;

  assign obsA = {aTick, aX, aY, aVid, aHs, aVs, aLs, aFs};
  assign obsB = {bTick, bX, bY, bVid, bHs, bVs, bLs, bFs};
  assign obsC = {cTick, cX, cY, cVid, cHs, cVs, cLs, cFs};

  vga_timing_gen #(
    .PIX_DIV(4), .SYNC_DELAY(1)
  ) dutA (
    .clk(clk), .rst(rst), .pix_tick(aTick), .pixel_x(aX), .pixel_y(aY),
    .video_on(aVid), .hsync(aHs), .vsync(aVs), .line_start(aLs), .frame_start(aFs)
  );

  vga_timing_gen #(
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .PIX_DIV(1), .SYNC_DELAY(0)
  ) dutB (
    .clk(clk), .rst(rst), .pix_tick(bTick), .pixel_x(bX), .pixel_y(bY),
    .video_on(bVid), .hsync(bHs), .vsync(bVs), .line_start(bLs), .frame_start(bFs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .PIX_DIV(3), .SYNC_DELAY(3)
  ) dutC (
    .clk(clk), .rst(rst), .pix_tick(cTick), .pixel_x(cX), .pixel_y(cY),
    .video_on(cVid), .hsync(cHs), .vsync(cVs), .line_start(cLs), .frame_start(cFs)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input int nClk);
    rst = rstVal;
    repeat (nClk) @(negedge clk);
  endtask

  // Expected outputs after the c-th clk edge since reset release
  // (c = 0 means the edge sampled rst high).
  function automatic logic [25:0] predict(input int i, input longint c);
    longint ht, vt, t, p, q, x, y, qx, qy;
    logic   pol, tick, vid, ls, fs, hs, vs;
    ht   = HA[i] + HFP[i] + HSW[i] + HBP[i];
    vt   = VA[i] + VFP[i] + VSW[i] + VBP[i];
    pol  = (POL[i] != 0);
    tick = (c >= PD[i]) && (c % PD[i] == 0);
    t    = (c >= 1) ? (c - 1) / PD[i] : 0;
    x = 0; y = 0; vid = 0; ls = 0; fs = 0; hs = ~pol; vs = ~pol;
    if (t > 0) begin
      p   = t - 1;
      x   = p % ht;
      y   = (p / ht) % vt;
      vid = (x < HA[i]) && (y < VA[i]);
      ls  = (x == 0);
      fs  = (x == 0) && (y == 0);
      q   = p - DL[i];
      if (q >= 0) begin
        qx = q % ht;
        qy = (q / ht) % vt;
        if (qx >= HA[i] + HFP[i] && qx < HA[i] + HFP[i] + HSW[i]) hs = pol;
        if (qy >= VA[i] + VFP[i] && qy < VA[i] + VFP[i] + VSW[i]) vs = pol;
      end
    end
    return {tick, x[9:0], y[9:0], vid, hs, vs, ls, fs};
  endfunction

  longint c   = 0;
  int     seg = 0;
  logic [77:0] expQ[$];

  always @(posedge clk) begin
    expQ.push_back({predict(2, rst ? 0 : c + 1),
                    predict(1, rst ? 0 : c + 1),
                    predict(0, rst ? 0 : c + 1)});
    if (!rst && c == 0) seg <= seg + 1;
    c <= rst ? 0 : c + 1;
  end

  int   aFirstTickC = -1, aVidClk = 0, aHsLowClk = 0, aLsRise = 0, aFallX = -1;
  int   bFallX = -1, bVsFallY = -1, bVsLowClk = 0, bFsRise = 0, bTickLowClk = 0;
  int   bLs1C = -1, bLs2C = -1;
  logic aHsPrev = 1'b1, aLsPrev = 1'b0;
  logic bHsPrev = 1'b1, bVsPrev = 1'b1, bLsPrev = 1'b0, bFsPrev = 1'b0;

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput("dutA", {6'd0, obsA}, {6'd0, expQ[0][25:0]});
      checkOutput("dutB", {6'd0, obsB}, {6'd0, expQ[0][51:26]});
      checkOutput("dutC", {6'd0, obsC}, {6'd0, expQ[0][77:52]});
      void'(expQ.pop_front());
    end
    if (seg == 1 && c >= 1 && c <= 11000) begin
      if (aTick && aFirstTickC < 0) aFirstTickC <= int'(c);
      if (aVid && aY == 10'd0) aVidClk <= aVidClk + 1;
      if (!aHs && aY == 10'd0) aHsLowClk <= aHsLowClk + 1;
      if (aLs && !aLsPrev) aLsRise <= aLsRise + 1;
      if (!aHs && aHsPrev && aFallX < 0) aFallX <= int'(aX);
      if (!bHs && bHsPrev && bFallX < 0) bFallX <= int'(bX);
      if (!bVs && bVsPrev && bVsFallY < 0) bVsFallY <= int'(bY);
      if (!bVs) bVsLowClk <= bVsLowClk + 1;
      if (bFs && !bFsPrev) bFsRise <= bFsRise + 1;
      if (!bTick) bTickLowClk <= bTickLowClk + 1;
      if (bLs && !bLsPrev) begin
        if (bLs1C < 0) bLs1C <= int'(c);
        else if (bLs2C < 0) bLs2C <= int'(c);
      end
    end
    if (seg == 2 && c == 5) begin
      checkOutput("restartA", {10'd0, aFs, aLs, aX, aY}, {10'd0, 1'b1, 1'b1, 20'd0});
    end
    aHsPrev <= aHs;
    aLsPrev <= aLs;
    bHsPrev <= bHs;
    bVsPrev <= bVs;
    bLsPrev <= bLs;
    bFsPrev <= bFs;
  end

  logic found;

  initial begin
    applyStimulus(1'b1, 4);
    checkOutput("rstA", {6'd0, obsA}, {6'd0, 1'b0, 20'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    checkOutput("rstC", {6'd0, obsC}, {6'd0, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    applyStimulus(1'b0, 11001);
    checkOutput("aFirstTick", aFirstTickC, 4);
    checkOutput("aVidClk", aVidClk, 640 * 4);
    checkOutput("aHsLowClk", aHsLowClk, 96 * 4);
    checkOutput("aHsFallX", aFallX, 657);
    checkOutput("aLsRise", aLsRise, 4);
    checkOutput("bHsFallX", bFallX, 656);
    checkOutput("bVsFallY", bVsFallY, 8);
    checkOutput("bVsLowClk", bVsLowClk, 1600);
    checkOutput("bFsRise", bFsRise, 2);
    checkOutput("bTickLow", bTickLowClk, 0);
    checkOutput("bLinePer", bLs2C - bLs1C, 800);

    found = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (aX == 10'd300) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("waitX300", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstA", {6'd0, obsA}, {6'd0, 1'b0, 20'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 3400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60Hz VGA raster timing: pixel coordinates, video_on, hsync, vsync and frame/line strobes.
- Drives the pixel_x/pixel_y/video_on inputs of the text display and the board hsync/vsync pins.
- Sync outputs are delayed by a configurable number of pixel ticks so they stay aligned with the display's registered RGB.
- Runs from the system clock, with an internal pixel-tick divider.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low, as 640x480 requires)
- PIX_DIV, 4, clk cycles per pixel tick (1..16; 4 gives 25 MHz from 100 MHz)
- SYNC_DELAY, 1, pixel ticks of delay on hsync/vsync relative to coordinates (0..3)

Ports:
- clk, input, 1, system clock
- rst, input, 1, synchronous active-high reset
- pix_tick, output, 1, one-clk pulse marking each pixel period
- pixel_x, output, 10, current horizontal count 0..H_TOTAL-1
- pixel_y, output, 10, current vertical count 0..V_TOTAL-1
- video_on, output, 1, high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- hsync, output, 1, horizontal sync, delayed SYNC_DELAY ticks
- vsync, output, 1, vertical sync, delayed SYNC_DELAY ticks
- line_start, output, 1, high for the one tick where pixel_x == 0
- frame_start, output, 1, high for the one tick where pixel_x == 0 and pixel_y == 0

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Values held during reset:
  - div_cnt, h_cnt, v_cnt = 0; pix_tick = 0.
  - pixel_x = pixel_y = 0; video_on = 0; line_start = 0; frame_start = 0.
  - hsync = vsync = ~SYNC_POL (deasserted), including every delay stage.
- Tick divider:
  - div_cnt counts 0..PIX_DIV-1 on each clk; pix_tick = 1 in the cycle div_cnt == PIX_DIV-1, then div_cnt wraps to 0.
  - PIX_DIV = 1: pix_tick is 1 on every cycle after reset.
  - First pix_tick occurs PIX_DIV clk cycles after rst deasserts.
- Counters and outputs change only on pix_tick cycles and hold otherwise.
- Output registers (pixel_x, pixel_y, video_on, line_start, frame_start) load the decode of (h_cnt, v_cnt), then the counters advance:
  - h_cnt == H_TOTAL-1 -> h_cnt = 0, and v_cnt increments (V_TOTAL-1 wraps to 0).
  - Otherwise h_cnt increments.
- Consequence: on the first pix_tick after reset the outputs present (0,0) with video_on = 1 and frame_start = 1, visible one clk after that tick.
- line_start and frame_start hold for the full pixel period (PIX_DIV clks).
- Raw sync, decoded from the same count:
  - hs_raw asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), for whole lines.
- Sync delay: SYNC_DELAY-stage shift register clocked on pix_tick; SYNC_DELAY = 0 makes hsync/vsync register-aligned with pixel_x.
- Boundaries:
  - Line wrap 799 -> 0 and frame wrap (799,524) -> (0,0) occur on the same tick with no gap.
  - line_start is also high on the frame_start tick.
- Reset mid-frame: all state returns to reset values on the next clk; the restart is identical to power-up.
- Elaboration checks: PIX_DIV < 1 or SYNC_DELAY > 3 raises an error.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants: H_ACTIVE..V_BP, H_TOTAL, V_TOTAL.
  - Coordinate width (10).
  - SYNC_POL default.
- The text display reuses vga_pkg for its active-area bounds.
- One natural sub-module, vga_pix_tick_div: the PIX_DIV counter producing pix_tick.
- Counters, decode and sync delay stay in the top module.

Test Plan:
- Reset release, PIX_DIV=4:
  - First pix_tick at clk 4.
  - pixel_x=0, pixel_y=0, video_on=1, frame_start=1, line_start=1.
  - hsync=vsync=1 throughout reset.
- One full line (800 ticks):
  - video_on high for exactly 640 ticks.
  - pixel_x sequence 0..799 then 0.
  - pixel_y increments exactly at the wrap.
  - line_start pulses once per line.
- hsync, SYNC_POL=0, SYNC_DELAY=1: hsync low for exactly 96 ticks, beginning on the tick after pixel_x=656.
- Full frame (420000 ticks):
  - vsync low for 1600 ticks, starting at line 490.
  - video_on low for all of lines 480..524.
  - frame_start pulses once per frame.
  - Next frame starts at (0,0).
- Reset mid-frame at pixel_x=300, pixel_y=200: next clk all outputs return to reset values; after release the frame restarts at (0,0) with frame_start=1.
- PIX_DIV=1, SYNC_DELAY=0:
  - pix_tick constant 1 after reset.
  - hsync falls in the same cycle pixel_x becomes 656.
  - Line period is exactly 800 clks.
